// File: rtl/isb_pf_sched_if.sv
// Bundle of trigger, SP-AMC lookup, demand and shared memory port signals
// of the ISB prefetch scheduler.
interface isb_pf_sched_if;
  logic        trig_v;
  logic [31:0] trig_sa;
  logic        sp_rd_v;
  logic [31:0] sp_rd_sa;
  logic        sp_rd_hit;
  logic [15:0] sp_rd_pa;
  logic        dem_v;
  logic [15:0] dem_addr;
  logic        mem_v;
  logic [15:0] mem_addr;
  logic        mem_pf;
  logic        mem_rdy;
  logic        busy;

  modport master (
    output trig_v, trig_sa, sp_rd_hit, sp_rd_pa, dem_v, dem_addr, mem_rdy,
    input  sp_rd_v, sp_rd_sa, mem_v, mem_addr, mem_pf, busy
  );

  modport slave (
    input  trig_v, trig_sa, sp_rd_hit, sp_rd_pa, dem_v, dem_addr, mem_rdy,
    output sp_rd_v, sp_rd_sa, mem_v, mem_addr, mem_pf, busy
  );
endinterface

// File: rtl/isb_pf_sched.sv
// ISB prefetch scheduler: walks the SP-AMC after a trigger, queues physical
// prefetch addresses and shares the memory port with demand traffic.
// Define ISB_PF_DEDUP_EN to drop pushes that match any queued entry.
module isb_pf_sched #(
  parameter int unsigned DEGREE = 2
) (
  input logic           clk,
  input logic           rst_n,
  isb_pf_sched_if.slave bus
);

  localparam logic [2:0] DEG_C = 3'(DEGREE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] cur_sa_r;
  logic [2:0]  cnt_r;
  logic [15:0] fifo_r [4];
  logic [1:0]  wr_ptr_r;
  logic [1:0]  rd_ptr_r;
  logic [2:0]  occ_r;

  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic [31:0] rd_sa_s;
  logic [2:0]  cnt_inc_s;
  logic        last_s;
  logic [15:0] tail_s;
  logic        dup_hit_s;
  logic        drop_s;
  logic        sp_rd_v_s;
  logic        push_s;
  logic        cnt_step_s;
  logic        busy_s;
  logic        pf_avail_s;
  logic        pop_s;

  assign fifo_full_s  = (occ_r == 3'd4);
  assign fifo_empty_s = (occ_r == 3'd0);
  assign rd_sa_s      = cur_sa_r + 32'd1 + {29'd0, cnt_r};
  assign cnt_inc_s    = cnt_r + 3'd1;
  // A stream stops at its degree or at the last address of a 16-entry block.
  assign last_s       = (cnt_inc_s == DEG_C) || (rd_sa_s[3:0] == 4'hF);
  assign tail_s       = fifo_r[wr_ptr_r - 2'd1];

`ifdef ISB_PF_DEDUP_EN
  logic [3:0] dup_vec_s;

  // Compare the returned address against every occupied slot.
  always_comb begin
    dup_vec_s = 4'd0;
    for (int i = 0; i < 4; i++) begin
      dup_vec_s[i] = (3'(i) < occ_r) && (fifo_r[rd_ptr_r + 2'(i)] == bus.sp_rd_pa);
    end
  end

  assign dup_hit_s = |dup_vec_s;
`else
  assign dup_hit_s = 1'b0;
`endif

  assign drop_s = (bus.dem_v && (bus.sp_rd_pa == bus.dem_addr)) ||
                  (!fifo_empty_s && (bus.sp_rd_pa == tail_s)) ||
                  dup_hit_s;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; a trigger restarts the walk from any state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.trig_v) state_nxt_s = ST_LOOKUP;
        else            state_nxt_s = ST_IDLE;
      end
      ST_LOOKUP: begin
        if (bus.trig_v)        state_nxt_s = ST_LOOKUP;
        else if (!fifo_full_s) state_nxt_s = ST_WAIT;
        else                   state_nxt_s = ST_LOOKUP;
      end
      ST_WAIT: begin
        if (bus.trig_v)          state_nxt_s = ST_LOOKUP;
        else if (!bus.sp_rd_hit) state_nxt_s = ST_IDLE;
        else if (last_s)         state_nxt_s = ST_IDLE;
        else                     state_nxt_s = ST_LOOKUP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: lookup request, FIFO push and walk-counter step.
  always_comb begin
    sp_rd_v_s  = 1'b0;
    push_s     = 1'b0;
    cnt_step_s = 1'b0;
    busy_s     = (state_r != ST_IDLE);
    case (state_r)
      ST_LOOKUP: begin
        if (!bus.trig_v && !fifo_full_s) sp_rd_v_s = 1'b1;
        else                             sp_rd_v_s = 1'b0;
      end
      ST_WAIT: begin
        if (!bus.trig_v && bus.sp_rd_hit) begin
          cnt_step_s = 1'b1;
          push_s     = !drop_s;
        end else begin
          cnt_step_s = 1'b0;
          push_s     = 1'b0;
        end
      end
      default: begin
        sp_rd_v_s  = 1'b0;
        push_s     = 1'b0;
        cnt_step_s = 1'b0;
      end
    endcase
  end

  // Walk position: reloaded on every trigger, advanced on each SP hit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_sa_r <= 32'd0;
      cnt_r    <= 3'd0;
    end else if (bus.trig_v) begin
      cur_sa_r <= bus.trig_sa;
      cnt_r    <= 3'd0;
    end else if (cnt_step_s) begin
      cnt_r    <= cnt_inc_s;
    end else begin
      cnt_r    <= cnt_r;
    end
  end

  // Prefetch FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      occ_r    <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        fifo_r[i] <= 16'd0;
      end
    end else begin
      if (push_s) begin
        fifo_r[wr_ptr_r] <= bus.sp_rd_pa;
        wr_ptr_r         <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + 3'd1;
        2'b01:   occ_r <= occ_r - 3'd1;
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Outputs are masked while reset is asserted so stale state never leaks.
  assign pf_avail_s   = rst_n && !fifo_empty_s;
  assign pop_s        = pf_avail_s && !bus.dem_v && bus.mem_rdy;
  assign bus.sp_rd_v  = rst_n && sp_rd_v_s;
  assign bus.sp_rd_sa = rd_sa_s;
  assign bus.busy     = rst_n && busy_s;
  assign bus.mem_v    = bus.dem_v || pf_avail_s;
  assign bus.mem_pf   = !bus.dem_v && pf_avail_s;
  assign bus.mem_addr = bus.dem_v ? bus.dem_addr : fifo_r[rd_ptr_r];

endmodule

// File: tb/tb_isb_pf_sched.sv
// Directed self-checking bench for isb_pf_sched (DEGREE=2) with a small
// synchronous SP-AMC model and a prefetch issue log.
module tb_isb_pf_sched;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  isb_pf_sched_if bus ();

  isb_pf_sched #(.DEGREE(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  bit          sp_hit_tab [256];
  logic [15:0] sp_pa_tab  [256];
  bit          sp_req_q = 1'b0;
  logic [31:0] sp_sa_q  = 32'd0;
  logic [31:0] sp_log [$];
  logic [15:0] pf_log [$];

  // Monitor: log SP reads and accepted prefetches mid-cycle.
  always @(negedge clk) begin
    sp_req_q = bus.sp_rd_v;
    sp_sa_q  = bus.sp_rd_sa;
    if (bus.sp_rd_v) sp_log.push_back(bus.sp_rd_sa);
    if (bus.mem_v && bus.mem_rdy && bus.mem_pf) pf_log.push_back(bus.mem_addr);
  end

  // SP-AMC model: answers the cycle after a read request.
  always @(posedge clk) begin
    #1;
    bus.sp_rd_hit = sp_req_q && sp_hit_tab[sp_sa_q[7:0]];
    bus.sp_rd_pa  = sp_pa_tab[sp_sa_q[7:0]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sp(input logic [7:0] sa, input logic [15:0] pa);
    sp_hit_tab[sa] = 1'b1;
    sp_pa_tab[sa]  = pa;
  endtask

  task automatic clear_logs();
    sp_log.delete();
    pf_log.delete();
  endtask

  task automatic trig(input logic [31:0] sa);
    bus.trig_v  = 1'b1;
    bus.trig_sa = sa;
    tick();
    bus.trig_v  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    @(negedge clk);
    while (bus.busy && k < 40) begin
      tick();
      @(negedge clk);
      k++;
    end
    check(tag, 32'(bus.busy), 32'd0);
    tick();
  endtask

  task automatic drain(input string tag);
    int k = 0;
    bus.mem_rdy = 1'b1;
    @(negedge clk);
    while ((bus.mem_v || bus.busy) && k < 40) begin
      tick();
      @(negedge clk);
      k++;
    end
    check(tag, 32'({bus.mem_v, bus.busy}), 32'd0);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      sp_hit_tab[i] = 1'b0;
      sp_pa_tab[i]  = 16'h0;
    end
    // Reset with trigger and demand active.
    rst_n        = 1'b0;
    bus.trig_v   = 1'b1;
    bus.trig_sa  = 32'h10;
    bus.dem_v    = 1'b1;
    bus.dem_addr = 16'h1234;
    bus.mem_rdy  = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_sp_rd_v", 32'(bus.sp_rd_v), 32'd0);
    check("rst_mem_v",   32'(bus.mem_v),   32'd1);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'h1234);
    check("rst_mem_pf",  32'(bus.mem_pf),  32'd0);
    check("rst_busy",    32'(bus.busy),    32'd0);
    tick();
    rst_n       = 1'b1;
    bus.trig_v  = 1'b0;
    bus.dem_v   = 1'b0;
    bus.mem_rdy = 1'b1;
    @(negedge clk);
    check("post_rst_busy",  32'(bus.busy),    32'd0);
    check("post_rst_mem_v", 32'(bus.mem_v),   32'd0);
    check("post_rst_sp_v",  32'(bus.sp_rd_v), 32'd0);

    // Basic DEGREE=2 walk from 0x10 with cycle-exact latency.
    set_sp(8'h11, 16'hA0);
    set_sp(8'h12, 16'hB0);
    set_sp(8'h13, 16'hC0);
    tick();
    clear_logs();
    bus.trig_v  = 1'b1;
    bus.trig_sa = 32'h10;
    @(negedge clk);
    check("a_t0_busy", 32'(bus.busy), 32'd0);
    tick();
    bus.trig_v = 1'b0;
    @(negedge clk);
    check("a_t1_sp_v",  32'(bus.sp_rd_v),  32'd1);
    check("a_t1_sp_sa", bus.sp_rd_sa,      32'h11);
    check("a_t1_busy",  32'(bus.busy),     32'd1);
    check("a_t1_mem_v", 32'(bus.mem_v),    32'd0);
    tick();
    @(negedge clk);
    check("a_t2_sp_v",  32'(bus.sp_rd_v),  32'd0);
    check("a_t2_mem_v", 32'(bus.mem_v),    32'd0);
    tick();
    @(negedge clk);
    check("a_t3_mem_v",    32'(bus.mem_v),    32'd1);
    check("a_t3_mem_addr", 32'(bus.mem_addr), 32'hA0);
    check("a_t3_mem_pf",   32'(bus.mem_pf),   32'd1);
    check("a_t3_sp_sa",    bus.sp_rd_sa,      32'h12);
    tick();
    @(negedge clk);
    check("a_t4_mem_v", 32'(bus.mem_v), 32'd0);
    tick();
    @(negedge clk);
    check("a_t5_mem_addr", 32'(bus.mem_addr), 32'hB0);
    check("a_t5_mem_pf",   32'(bus.mem_pf),   32'd1);
    check("a_t5_busy",     32'(bus.busy),     32'd0);
    tick();
    @(negedge clk);
    check("a_t6_mem_v", 32'(bus.mem_v), 32'd0);
    check("a_sp_reads", 32'(sp_log.size()), 32'd2);
    tick();

    // Stream boundary at sa 0x1F stops before the degree is reached.
    set_sp(8'h1F, 16'hD0);
    set_sp(8'h20, 16'hE0);
    clear_logs();
    trig(32'h1E);
    wait_idle("b_idle");
    drain("b_drain");
    check("b_sp_n",  32'(sp_log.size()), 32'd1);
    check("b_sp_0",  sp_log[0],          32'h1F);
    check("b_pf_n",  32'(pf_log.size()), 32'd1);
    check("b_pf_0",  32'(pf_log[0]),     32'hD0);

    // Non-adjacent duplicate of a queued entry.
    set_sp(8'h31, 16'hA0);
    set_sp(8'h32, 16'h77);
    clear_logs();
    bus.mem_rdy = 1'b0;
    trig(32'h10);
    wait_idle("c_idle0");
    trig(32'h30);
    wait_idle("c_idle1");
    drain("c_drain");
`ifdef ISB_PF_DEDUP_EN
    check("c_pf_n", 32'(pf_log.size()), 32'd3);
    check("c_pf_2", 32'(pf_log[2]),     32'h77);
`else
    check("c_pf_n", 32'(pf_log.size()), 32'd4);
    check("c_pf_2", 32'(pf_log[2]),     32'hA0);
    check("c_pf_3", 32'(pf_log[3]),     32'h77);
`endif
    check("c_pf_0", 32'(pf_log[0]), 32'hA0);
    check("c_pf_1", 32'(pf_log[1]), 32'hB0);

    // Tail filter, then demand-address filter while demand holds the port.
    set_sp(8'h41, 16'h55);
    set_sp(8'h42, 16'h55);
    set_sp(8'h51, 16'h66);
    set_sp(8'h52, 16'h67);
    clear_logs();
    bus.mem_rdy = 1'b0;
    trig(32'h40);
    wait_idle("d_idle0");
    bus.dem_v    = 1'b1;
    bus.dem_addr = 16'h66;
    trig(32'h50);
    wait_idle("d_idle1");
    bus.dem_addr = 16'h1234;
    bus.mem_rdy  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("d_dem_mem_v",    32'(bus.mem_v),    32'd1);
      check("d_dem_mem_addr", 32'(bus.mem_addr), 32'h1234);
      check("d_dem_mem_pf",   32'(bus.mem_pf),   32'd0);
      tick();
    end
    bus.dem_v = 1'b0;
    @(negedge clk);
    check("d_pf0_addr", 32'(bus.mem_addr), 32'h55);
    check("d_pf0_pf",   32'(bus.mem_pf),   32'd1);
    tick();
    @(negedge clk);
    check("d_pf1_addr", 32'(bus.mem_addr), 32'h67);
    check("d_pf1_pf",   32'(bus.mem_pf),   32'd1);
    tick();
    @(negedge clk);
    check("d_empty_mem_v", 32'(bus.mem_v), 32'd0);
    tick();

    // Fill the FIFO, hold in LOOKUP while full, then drain in order.
    set_sp(8'h61, 16'h81);
    set_sp(8'h62, 16'h82);
    set_sp(8'h71, 16'h83);
    set_sp(8'h72, 16'h84);
    set_sp(8'h81, 16'h85);
    set_sp(8'h82, 16'h86);
    clear_logs();
    bus.mem_rdy = 1'b0;
    trig(32'h60);
    wait_idle("e_idle0");
    trig(32'h70);
    wait_idle("e_idle1");
    trig(32'h80);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("e_full_busy", 32'(bus.busy),    32'd1);
      check("e_full_sp_v", 32'(bus.sp_rd_v), 32'd0);
      tick();
    end
    drain("e_drain");
    check("e_pf_n", 32'(pf_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check("e_pf_order", 32'(pf_log[i]), 32'h81 + 32'(i));
    end
    check("e_sp_n", 32'(sp_log.size()), 32'd6);

    // Trigger during WAIT discards the outstanding response.
    set_sp(8'hC1, 16'h21);
    set_sp(8'hC2, 16'h22);
    set_sp(8'hD1, 16'h31);
    set_sp(8'hD2, 16'h32);
    clear_logs();
    trig(32'hC0);
    tick();
    trig(32'hD0);
    wait_idle("f_idle");
    drain("f_drain");
    check("f_pf_n", 32'(pf_log.size()), 32'd2);
    check("f_pf_0", 32'(pf_log[0]),     32'h31);
    check("f_pf_1", 32'(pf_log[1]),     32'h32);
    check("f_sp_n", 32'(sp_log.size()), 32'd3);
    check("f_sp_1", sp_log[1],          32'hD1);

    // Reset while in WAIT with two queued prefetches.
    set_sp(8'hA1, 16'h10);
    set_sp(8'hA2, 16'h11);
    set_sp(8'hB1, 16'h12);
    clear_logs();
    bus.mem_rdy = 1'b0;
    trig(32'hA0);
    wait_idle("g_idle");
    trig(32'hB0);
    @(negedge clk);
    check("g_lookup_sp_v", 32'(bus.sp_rd_v), 32'd1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("g_rst_busy",  32'(bus.busy),    32'd0);
    check("g_rst_mem_v", 32'(bus.mem_v),   32'd0);
    check("g_rst_sp_v",  32'(bus.sp_rd_v), 32'd0);
    tick();
    rst_n       = 1'b1;
    bus.mem_rdy = 1'b1;
    @(negedge clk);
    check("g_post_busy",  32'(bus.busy),  32'd0);
    check("g_post_mem_v", 32'(bus.mem_v), 32'd0);
    tick();
    @(negedge clk);
    check("g_post2_mem_v", 32'(bus.mem_v), 32'd0);
    tick();
    bus.dem_v    = 1'b1;
    bus.dem_addr = 16'h0BEE;
    @(negedge clk);
    check("g_dem_mem_v",    32'(bus.mem_v),    32'd1);
    check("g_dem_mem_pf",   32'(bus.mem_pf),   32'd0);
    check("g_dem_mem_addr", 32'(bus.mem_addr), 32'h0BEE);
    tick();
    bus.dem_v = 1'b0;
    check("g_pf_n", 32'(pf_log.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
